otter_intr_ctrl: RTL and testbench

Trap/interrupt sequencer for the pipelined OTTER core, acting as the initiator side of the CSR trap interface.
- Detects the external interrupt and decides when to take it from CSR_MIE.
- Drives INT_TAKEN and the saved PC into the CSR file, and redirects fetch to CSR_MTVEC.
- On mret, redirects fetch to CSR_MEPC.
- Sits between the CSR file, writeback-stage control and the PC-select mux.

---
 rtl/otter_intr_pkg.sv | 22 ++
 rtl/otter_intr_sync.sv | 44 ++++
 rtl/otter_intr_ctrl.sv | 100 ++++++++++
 tb/tb_otter_intr_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/otter_intr_pkg.sv
// rtl/otter_intr_pkg.sv - shared types and constants for the OTTER trap sequencer
package otter_intr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    TAKE  = 3'd2,
    RET   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam logic [11:0] CSR_ADDR_MIE   = 12'h304;
  localparam logic [11:0] CSR_ADDR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_ADDR_MEPC  = 12'h341;

  localparam int DRAIN_CYCLES_DEF = 3;

  function automatic logic is_busy(input state_t s);
    return (s == TAKE) || (s == RET) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/otter_intr_sync.sv
// rtl/otter_intr_sync.sv - INTR conditioning and rising-edge detect
// OTTER_INTR_SYNC_EN adds a 2-flop synchronizer ahead of the edge detector.
module otter_intr_sync (
  input  logic CLK,
  input  logic RST,
  input  logic INTR,
  output logic RISE
);

  logic w_cond;

`ifdef OTTER_INTR_SYNC_EN
  localparam int ARM_W = 3;
  logic [1:0] r_sync;

  always_ff @(posedge CLK) begin
    if (RST) r_sync <= '0;
    else     r_sync <= {r_sync[0], INTR};
  end

  assign w_cond = r_sync[1];
`else
  localparam int ARM_W = 1;
  assign w_cond = INTR;
`endif

  logic             r_edge;
  logic [ARM_W-1:0] r_arm;

  // A level already high when reset releases is not an edge: r_arm holds off
  // detection until the edge flop has seen the conditioned level once.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_edge <= 1'b0;
      r_arm  <= '0;
    end else begin
      r_edge <= w_cond;
      r_arm  <= (r_arm << 1) | ARM_W'(1);
    end
  end

  assign RISE = w_cond & ~r_edge & r_arm[ARM_W-1];

endmodule

// File: rtl/otter_intr_ctrl.sv
// rtl/otter_intr_ctrl.sv - trap/interrupt sequencer driving CSR trap and PC redirect
// Optional input synchronizer selected by OTTER_INTR_SYNC_EN (see otter_intr_sync).
module otter_intr_ctrl
  import otter_intr_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INTR,
  input  logic        CSR_MIE,
  input  logic [31:0] CSR_MTVEC,
  input  logic [31:0] CSR_MEPC,
  input  logic        MRET,
  input  logic        BOUNDARY,
  input  logic [31:0] WB_PC,
  output logic        INT_TAKEN,
  output logic [31:0] EPC_OUT,
  output logic        REDIRECT,
  output logic [31:0] REDIRECT_PC,
  output logic        FLUSH,
  output logic        BUSY
);

  logic w_rise;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic r_pending;
  logic r_int_taken, r_redirect, r_busy;
  logic [31:0] r_epc, r_redirect_pc;

  otter_intr_sync u_sync (
    .CLK  (CLK),
    .RST  (RST),
    .INTR (INTR),
    .RISE (w_rise)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (MRET)                       w_next = RET;
        else if (r_pending && CSR_MIE)  w_next = ARMED;
      end
      ARMED: begin
        if (MRET)          w_next = RET;
        else if (!CSR_MIE) w_next = IDLE;
        else if (BOUNDARY) w_next = TAKE;
      end
      TAKE, RET: w_next = (DRAIN_CYCLES > 1) ? DRAIN : IDLE;
      DRAIN: begin
        if (r_cnt == CNT_W'(DRAIN_CYCLES - 1)) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Outputs are registered off the next state so they line up with it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt         <= '0;
      r_pending     <= 1'b0;
      r_int_taken   <= 1'b0;
      r_redirect    <= 1'b0;
      r_busy        <= 1'b0;
      r_epc         <= '0;
      r_redirect_pc <= '0;
    end else begin
      r_cnt       <= (w_next == DRAIN) ? r_cnt + CNT_W'(1) : '0;
      r_int_taken <= (w_next == TAKE);
      r_redirect  <= (w_next == TAKE) || (w_next == RET);
      r_busy      <= is_busy(w_next);

      if (w_next == TAKE) r_pending <= 1'b0;
      else if (w_rise)    r_pending <= 1'b1;

      if (w_next == TAKE) begin
        r_epc         <= WB_PC;
        r_redirect_pc <= CSR_MTVEC;
      end else if (w_next == RET && !is_busy(r_state)) begin
        r_redirect_pc <= CSR_MEPC;
      end
    end
  end

  assign INT_TAKEN   = r_int_taken;
  assign EPC_OUT     = r_epc;
  assign REDIRECT    = r_redirect;
  assign REDIRECT_PC = r_redirect_pc;
  assign FLUSH       = r_busy;
  assign BUSY        = r_busy;

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// tb/tb_otter_intr_ctrl.sv - directed self-checking bench for otter_intr_ctrl
module tb_otter_intr_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        INTR;
  logic        CSR_MIE;
  logic [31:0] CSR_MTVEC;
  logic [31:0] CSR_MEPC;
  logic        MRET;
  logic        BOUNDARY;
  logic [31:0] WB_PC;
  logic        INT_TAKEN;
  logic [31:0] EPC_OUT;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        FLUSH;
  logic        BUSY;

  int n_checks = 0;
  int n_errors = 0;
  int cnt;
  int cnt2;
  int first_idx;

  otter_intr_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .INTR        (INTR),
    .CSR_MIE     (CSR_MIE),
    .CSR_MTVEC   (CSR_MTVEC),
    .CSR_MEPC    (CSR_MEPC),
    .MRET        (MRET),
    .BOUNDARY    (BOUNDARY),
    .WB_PC       (WB_PC),
    .INT_TAKEN   (INT_TAKEN),
    .EPC_OUT     (EPC_OUT),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .FLUSH       (FLUSH),
    .BUSY        (BUSY)
  );

  initial forever #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    // Reset with INTR already high
    RST = 1'b1; INTR = 1'b1; CSR_MIE = 1'b1; BOUNDARY = 1'b1; MRET = 1'b0;
    CSR_MTVEC = 32'h100; CSR_MEPC = 32'h0; WB_PC = 32'h40;
    tick(); tick();
    check("rst_int_taken", INT_TAKEN, 0);
    check("rst_redirect", REDIRECT, 0);
    check("rst_flush", FLUSH, 0);
    check("rst_busy", BUSY, 0);
    check("rst_epc", EPC_OUT, 0);
    check("rst_redir_pc", REDIRECT_PC, 0);
    check("rst_pending", dut.r_pending, 0);
    RST = 1'b0;
    cnt = 0;
    repeat (5) begin tick(); cnt += int'(INT_TAKEN); end
    check("rst_no_take", cnt, 0);
    check("rst_no_pending", dut.r_pending, 0);
    INTR = 1'b0; BOUNDARY = 1'b0;
    tick(); tick();

    // Basic take
    CSR_MIE = 1'b1; CSR_MTVEC = 32'h100; WB_PC = 32'h40;
    INTR = 1'b1;
    tick();
    check("take_pending", dut.r_pending, 1);
    check("take_early", INT_TAKEN, 0);
    BOUNDARY = 1'b1;
    tick();
    check("take_armed_no_pulse", INT_TAKEN, 0);
    tick();
    check("take_int_taken", INT_TAKEN, 1);
    check("take_redirect", REDIRECT, 1);
    check("take_epc", EPC_OUT, 32'h40);
    check("take_redir_pc", REDIRECT_PC, 32'h100);
    check("take_busy", BUSY, 1);
    check("take_pending_clr", dut.r_pending, 0);
    BOUNDARY = 1'b0;
    cnt = 1; cnt2 = 1;
    repeat (5) begin tick(); cnt += int'(FLUSH); cnt2 += int'(INT_TAKEN); end
    check("take_flush_len", cnt, 3);
    check("take_one_pulse", cnt2, 1);
    check("take_level_no_requeue", dut.r_pending, 0);
    INTR = 1'b0;
    tick();

    // Masked interrupt, later enabled
    CSR_MIE = 1'b0; BOUNDARY = 1'b0;
    INTR = 1'b1; tick(); INTR = 1'b0; tick();
    cnt = 0;
    repeat (10) begin tick(); cnt += int'(INT_TAKEN); end
    check("mask_no_take", cnt, 0);
    check("mask_pending_held", dut.r_pending, 1);
    CSR_MIE = 1'b1; BOUNDARY = 1'b1; WB_PC = 32'h48;
    cnt = 0; first_idx = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (INT_TAKEN) begin
        cnt++;
        if (first_idx < 0) first_idx = i;
      end
    end
    check("mask_take_count", cnt, 1);
    check("mask_take_latency", first_idx, 2);
    CSR_MIE = 1'b0; BOUNDARY = 1'b0;
    tick();

    // mret
    CSR_MEPC = 32'h44; MRET = 1'b1;
    tick();
    check("mret_redirect", REDIRECT, 1);
    check("mret_redir_pc", REDIRECT_PC, 32'h44);
    check("mret_flush", FLUSH, 1);
    check("mret_no_int", INT_TAKEN, 0);
    MRET = 1'b0; CSR_MEPC = 32'h99;
    tick();
    check("mret_redirect_off", REDIRECT, 0);
    check("mret_pc_held", REDIRECT_PC, 32'h44);
    check("mret_flush2", FLUSH, 1);
    tick();
    check("mret_flush3", FLUSH, 1);
    tick();
    check("mret_flush_end", FLUSH, 0);
    check("mret_busy_end", BUSY, 0);

    // Collision: MRET and BOUNDARY together while ARMED
    CSR_MIE = 1'b1; CSR_MTVEC = 32'h200; CSR_MEPC = 32'h80; WB_PC = 32'h60;
    INTR = 1'b1; tick();
    INTR = 1'b0; tick();
    MRET = 1'b1; BOUNDARY = 1'b1;
    tick();
    check("coll_ret_redirect", REDIRECT, 1);
    check("coll_ret_no_int", INT_TAKEN, 0);
    check("coll_ret_pc", REDIRECT_PC, 32'h80);
    check("coll_pending_kept", dut.r_pending, 1);
    MRET = 1'b0;
    cnt = 0;
    repeat (4) begin tick(); cnt += int'(INT_TAKEN); end
    check("coll_drain_ignores", cnt, 0);
    tick();
    check("coll_int_taken", INT_TAKEN, 1);
    check("coll_epc", EPC_OUT, 32'h60);
    check("coll_mtvec", REDIRECT_PC, 32'h200);
    BOUNDARY = 1'b0; CSR_MIE = 1'b0;
    repeat (4) tick();

    // Reset in the second FLUSH cycle
    CSR_MIE = 1'b1; WB_PC = 32'h70;
    INTR = 1'b1; tick();
    INTR = 1'b0; tick();
    BOUNDARY = 1'b1;
    tick();
    check("mid_take", INT_TAKEN, 1);
    BOUNDARY = 1'b0; INTR = 1'b1;
    tick();
    check("mid_flush2", FLUSH, 1);
    check("mid_pending_set", dut.r_pending, 1);
    RST = 1'b1;
    tick();
    check("mid_rst_flush", FLUSH, 0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_pending", dut.r_pending, 0);
    check("mid_rst_state", dut.r_state, 0);
    RST = 1'b0; INTR = 1'b0; CSR_MIE = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
